// File: rtl/adder_pkg.sv
// ============================================================================
//  Module      : adder_pkg
//  Description : Shared sizing constants and stage/skew helpers for adder_pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_pkg;

    localparam int ADD_WIDTH = 16;
    localparam int ADD_SLICE = 4;

    function automatic int stages_of(input int width, input int slice);
        return width / slice;
    endfunction

    // Bit offset of stage k's operand-B skew register inside the packed skew
    // vector; stage k keeps the (n-1-k) slices still waiting to be added.
    function automatic int skew_offset(input int k, input int n, input int slice);
        return slice * (k * (n - 1) - (k * (k - 1)) / 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/add_slice.sv
// ============================================================================
//  Module      : add_slice
//  Description : Combinational SLICE-bit ripple adder made of full-adder cells.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_slice
    import adder_pkg::*;
#(
    parameter int SLICE = ADD_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [SLICE:0] w_c;

    assign w_c[0] = ci;

    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        assign s[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign co    = w_c[SLICE];
    assign c_msb = w_c[SLICE-1];

endmodule

`default_nettype wire

// File: rtl/adder_pipe.sv
// ============================================================================
//  Module      : adder_pipe
//  Description : Pipelined WIDTH-bit adder/subtractor, one SLICE per stage,
//                with valid/ready backpressure and a global advance enable.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int SLICE = ADD_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int C_STAGES    = stages_of(WIDTH, SLICE);
    localparam int C_SKEW_BITS = (C_STAGES > 1) ? skew_offset(C_STAGES - 1, C_STAGES, SLICE) : 1;

    logic                   w_advance;
    logic [WIDTH-1:0]       w_b_eff;
    logic                   w_c0;
    logic                   w_last_c_msb;

    logic [C_STAGES-1:0]    valid_q;
    logic [C_STAGES-1:0]    valid_d;
    logic [C_STAGES-1:0]    carry_q;
    wire  [C_STAGES-1:0]    carry_d;
    // Each word starts as operand A; every stage consumes its low slice and
    // shifts its sum slice in at the top, so the last stage holds the result.
    logic [WIDTH-1:0]       sa_q [C_STAGES];
    wire  [WIDTH-1:0]       sa_d [C_STAGES];
    logic [C_SKEW_BITS-1:0] bskew_q;
    wire  [C_SKEW_BITS-1:0] bskew_d;
    logic                   ovf_q;
    logic                   ovf_d;

    always_comb begin
        w_advance = !valid_q[C_STAGES-1] || out_ready;
        w_b_eff   = sub ? ~b : b;
        w_c0      = ci ^ sub;
        valid_d   = '0;
        valid_d[0] = in_valid;
        for (int k = 1; k < C_STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
        end
        ovf_d = w_last_c_msb ^ carry_d[C_STAGES-1];
    end

    for (genvar k = 0; k < C_STAGES; k++) begin : g_stage
        localparam int C_BIN_W = (C_STAGES - k) * SLICE;

        logic [WIDTH-1:0]   w_sa_in;
        logic [C_BIN_W-1:0] w_b_in;
        logic               w_c_in;
        logic [SLICE-1:0]   w_sum;

        if (k == 0) begin : g_head
            assign w_sa_in = a;
            assign w_b_in  = w_b_eff;
            assign w_c_in  = w_c0;
        end else begin : g_body
            assign w_sa_in = sa_q[k-1];
            assign w_b_in  = bskew_q[skew_offset(k - 1, C_STAGES, SLICE) +: C_BIN_W];
            assign w_c_in  = carry_q[k-1];
        end

        if (k == C_STAGES - 1) begin : g_tail
            add_slice #(.SLICE(SLICE)) u_slice (
                .a     (w_sa_in[SLICE-1:0]),
                .b     (w_b_in[SLICE-1:0]),
                .ci    (w_c_in),
                .s     (w_sum),
                .co    (carry_d[k]),
                .c_msb (w_last_c_msb)
            );
        end else begin : g_mid
            logic w_c_msb_unused;

            add_slice #(.SLICE(SLICE)) u_slice (
                .a     (w_sa_in[SLICE-1:0]),
                .b     (w_b_in[SLICE-1:0]),
                .ci    (w_c_in),
                .s     (w_sum),
                .co    (carry_d[k]),
                .c_msb (w_c_msb_unused)
            );

            assign bskew_d[skew_offset(k, C_STAGES, SLICE) +: (C_BIN_W - SLICE)] = w_b_in[C_BIN_W-1:SLICE];
        end

        assign sa_d[k] = WIDTH'({w_sum, w_sa_in} >> SLICE);
    end

    // Operand-B skew is pure data; it only needs to follow the advance enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < C_STAGES; k++) begin
                sa_q[k] <= '0;
            end
        end else if (w_advance) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            bskew_q <= bskew_d;
            for (int k = 0; k < C_STAGES; k++) begin
                sa_q[k] <= sa_d[k];
            end
        end
    end

    assign in_ready  = w_advance;
    assign out_valid = valid_q[C_STAGES-1];
    assign s         = sa_q[C_STAGES-1];
    assign co        = carry_q[C_STAGES-1];
    assign ovf       = ovf_q;

endmodule

`default_nettype wire
